// File: rtl/fewcore_pkg.sv
// Shared fewcore definitions: load opcode, funct3 encodings, memory-stage state
// and the load decode helpers used by the read stage.
package fewcore_pkg;

   localparam logic [6:0] OPC_LOAD = 7'b0000011;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {IDLE, WAIT} state_t;

   // A load opcode with an undefined funct3 is handled as an ordinary pass-through.
   function automatic logic is_load(input logic [11:0] code);
      logic r;
      case (code[9:7])
         F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: r = (code[6:0] == OPC_LOAD);
         default:                             r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      logic r;
      case (funct3)
         F3_LH, F3_LHU: r = off[0];
         F3_LW:         r = (off != 2'b00);
         default:       r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_read_if.sv
// Data-memory read port: request/address out of the load stage, ready/data back.
interface mem_read_if #(parameter int XLEN = 32);
   logic            memReadReq;
   logic [XLEN-1:0] memAddress;
   logic            memReady;
   logic [XLEN-1:0] memData;

   modport master (output memReadReq, memAddress, input memReady, memData);
   modport slave  (input memReadReq, memAddress, output memReady, memData);
endinterface

// File: rtl/mem_read_load_align.sv
// Combinational lane select and sign/zero extension of a loaded word.
module load_align
   import fewcore_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] memData,
   input  logic [1:0]      addr,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] result
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      case (addr)
         2'd0:    byte_lane = memData[7:0];
         2'd1:    byte_lane = memData[15:8];
         2'd2:    byte_lane = memData[23:16];
         default: byte_lane = memData[31:24];
      endcase
      half_lane = addr[1] ? memData[31:16] : memData[15:0];
   end

   always_comb begin
      case (funct3)
         F3_LB:   result = {{(XLEN-8){byte_lane[7]}}, byte_lane};
         F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_lane};
         F3_LH:   result = {{(XLEN-16){half_lane[15]}}, half_lane};
         F3_LHU:  result = {{(XLEN-16){1'b0}}, half_lane};
         default: result = memData;
      endcase
   end

endmodule

// File: rtl/mem_read.sv
// Load-side memory stage: issues word reads for loads, waits on memReady with a
// timeout, and drives the register-file write port; other instructions pass through.
module mem_read
   import fewcore_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int XLEN    = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            validIn,
   input  logic            writeEnabled,
   input  logic [11:0]     code,
   input  logic [4:0]      rd,
   input  logic [XLEN-1:0] dataAlu,
   mem_read_if.master      mem,
   output logic [4:0]      rdAddress,
   output logic            writeEnabled_echo,
   output logic [XLEN-1:0] dataOut,
   output logic            stall,
   output logic            misaligned,
   output logic            busError
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t          state, state_d;
   logic [CW-1:0]   cnt, cnt_d;
   logic            req_q, req_d;
   logic [XLEN-1:0] maddr_q, maddr_d;
   logic [4:0]      rd_l, rd_l_d;
   logic [2:0]      f3_l, f3_l_d;
   logic [1:0]      off_l, off_l_d;
   logic            we_l, we_l_d;
   logic [4:0]      rda_d;
   logic            wee_d, mis_d, berr_d;
   logic [XLEN-1:0] dout_d;
   logic [XLEN-1:0] load_data;

   load_align #(.XLEN(XLEN)) u_align (
      .memData (mem.memData),
      .addr    (off_l),
      .funct3  (f3_l),
      .result  (load_data)
   );

   assign mem.memReadReq = req_q;
   assign mem.memAddress = maddr_q;
   assign stall          = (state == WAIT);

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      req_d   = req_q;
      maddr_d = maddr_q;
      rd_l_d  = rd_l;
      f3_l_d  = f3_l;
      off_l_d = off_l;
      we_l_d  = we_l;
      rda_d   = rdAddress;
      dout_d  = dataOut;
      wee_d   = 1'b0;
      mis_d   = 1'b0;
      berr_d  = 1'b0;
      unique case (state)
         IDLE: begin
            if (validIn) begin
               if (is_load(code)) begin
                  // Misaligned loads are dropped here; the write port keeps its old value.
                  if (is_misaligned(code[9:7], dataAlu[1:0])) begin
                     mis_d = 1'b1;
                  end else begin
                     state_d = WAIT;
                     req_d   = 1'b1;
                     maddr_d = {dataAlu[XLEN-1:2], 2'b00};
                     rd_l_d  = rd;
                     f3_l_d  = code[9:7];
                     off_l_d = dataAlu[1:0];
                     we_l_d  = writeEnabled;
                     cnt_d   = '0;
                  end
               end else begin
                  rda_d  = rd;
                  dout_d = dataAlu;
                  wee_d  = writeEnabled && (rd != 5'd0);
               end
            end
         end
         WAIT: begin
            // Data arriving on the last allowed cycle still completes the load.
            if (mem.memReady) begin
               state_d = IDLE;
               req_d   = 1'b0;
               dout_d  = load_data;
               rda_d   = rd_l;
               wee_d   = we_l && (rd_l != 5'd0);
            end else if (cnt == CNT_LAST) begin
               state_d = IDLE;
               req_d   = 1'b0;
               berr_d  = 1'b1;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         cnt               <= '0;
         req_q             <= 1'b0;
         maddr_q           <= '0;
         rd_l              <= '0;
         f3_l              <= '0;
         off_l             <= '0;
         we_l              <= 1'b0;
         rdAddress         <= '0;
         writeEnabled_echo <= 1'b0;
         dataOut           <= '0;
         misaligned        <= 1'b0;
         busError          <= 1'b0;
      end else begin
         state             <= state_d;
         cnt               <= cnt_d;
         req_q             <= req_d;
         maddr_q           <= maddr_d;
         rd_l              <= rd_l_d;
         f3_l              <= f3_l_d;
         off_l             <= off_l_d;
         we_l              <= we_l_d;
         rdAddress         <= rda_d;
         writeEnabled_echo <= wee_d;
         dataOut           <= dout_d;
         misaligned        <= mis_d;
         busError          <= berr_d;
      end
   end

endmodule

// File: tb/tb_mem_read.sv
// Directed bench for mem_read: pass-through, load extension, wait states,
// misalignment, timeout, reset during a load and rd=0 writes.
module tb_mem_read;
   import fewcore_pkg::*;

   logic        clk = 1'b0;
   logic        rst, validIn, writeEnabled;
   logic [11:0] code;
   logic [4:0]  rd;
   logic [31:0] dataAlu;
   logic [4:0]  rdAddress;
   logic        writeEnabled_echo, stall, misaligned, busError;
   logic [31:0] dataOut;
   int          tests = 0;
   int          fails = 0;

   mem_read_if #(.XLEN(32)) mem ();

   mem_read #(.TIMEOUT(16), .XLEN(32)) dut (
      .clk               (clk),
      .rst               (rst),
      .validIn           (validIn),
      .writeEnabled      (writeEnabled),
      .code              (code),
      .rd                (rd),
      .dataAlu           (dataAlu),
      .mem               (mem.master),
      .rdAddress         (rdAddress),
      .writeEnabled_echo (writeEnabled_echo),
      .dataOut           (dataOut),
      .stall             (stall),
      .misaligned        (misaligned),
      .busError          (busError)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [11:0] c, input logic [4:0] r, input logic [31:0] a);
      validIn = 1'b1; writeEnabled = 1'b1; code = c; rd = r; dataAlu = a;
      step();
      validIn = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; validIn = 1'b0; writeEnabled = 1'b0; code = '0; rd = '0; dataAlu = '0;
      mem.memReady = 1'b0; mem.memData = '0;
      step(); step();
      tests++; if (mem.memReadReq !== 1'b0) begin fails++; $display("FAIL rst_req got %b exp 0", mem.memReadReq); end
      tests++; if (mem.memAddress !== 32'h0) begin fails++; $display("FAIL rst_addr got %h exp 0", mem.memAddress); end
      tests++; if ({rdAddress, writeEnabled_echo, stall, misaligned, busError} !== 9'h0) begin
         fails++; $display("FAIL rst_ctl got %h exp 0", {rdAddress, writeEnabled_echo, stall, misaligned, busError}); end
      tests++; if (dataOut !== 32'h0) begin fails++; $display("FAIL rst_data got %h exp 0", dataOut); end
      rst = 1'b0;
   endtask

   task automatic test_passthrough();
      issue(12'h033, 5'd5, 32'h1234);
      tests++; if (rdAddress !== 5'd5) begin fails++; $display("FAIL pt_rd got %0d exp 5", rdAddress); end
      tests++; if (dataOut !== 32'h1234) begin fails++; $display("FAIL pt_data got %h exp 1234", dataOut); end
      tests++; if (writeEnabled_echo !== 1'b1) begin fails++; $display("FAIL pt_we got %b exp 1", writeEnabled_echo); end
      tests++; if (mem.memReadReq !== 1'b0) begin fails++; $display("FAIL pt_req got %b exp 0", mem.memReadReq); end
      step();
      tests++; if (writeEnabled_echo !== 1'b0) begin fails++; $display("FAIL pt_we_pulse got %b exp 0", writeEnabled_echo); end
   endtask

   task automatic test_lb_sext();
      mem.memReady = 1'b1; mem.memData = 32'h80FF_0000;
      issue(12'h003, 5'd3, 32'h103);
      tests++; if (mem.memReadReq !== 1'b1) begin fails++; $display("FAIL lb_req got %b exp 1", mem.memReadReq); end
      tests++; if (mem.memAddress !== 32'h100) begin fails++; $display("FAIL lb_addr got %h exp 100", mem.memAddress); end
      tests++; if (writeEnabled_echo !== 1'b0 || stall !== 1'b1) begin
         fails++; $display("FAIL lb_accept got we=%b stall=%b exp we=0 stall=1", writeEnabled_echo, stall); end
      step();
      tests++; if (dataOut !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_data got %h exp ffffff80", dataOut); end
      tests++; if (writeEnabled_echo !== 1'b1 || rdAddress !== 5'd3) begin
         fails++; $display("FAIL lb_wr got we=%b rd=%0d exp we=1 rd=3", writeEnabled_echo, rdAddress); end
      tests++; if (mem.memReadReq !== 1'b0 || stall !== 1'b0) begin
         fails++; $display("FAIL lb_done got req=%b stall=%b exp 0 0", mem.memReadReq, stall); end
      step();
      tests++; if (writeEnabled_echo !== 1'b0) begin fails++; $display("FAIL lb_we_pulse got %b exp 0", writeEnabled_echo); end
      mem.memReady = 1'b0;
   endtask

   task automatic test_lhu_wait();
      int stall_cycles;
      stall_cycles = 0;
      mem.memData = 32'hBEEF_1234;
      issue(12'h283, 5'd7, 32'h202);
      for (int i = 0; i < 3; i++) begin
         if (stall === 1'b1) stall_cycles++;
         tests++; if (mem.memAddress !== 32'h200 || mem.memReadReq !== 1'b1) begin
            fails++; $display("FAIL lhu_hold got req=%b addr=%h exp 1 200", mem.memReadReq, mem.memAddress); end
         step();
      end
      if (stall === 1'b1) stall_cycles++;
      mem.memReady = 1'b1;
      step();
      mem.memReady = 1'b0;
      tests++; if (stall_cycles != 4 || stall !== 1'b0) begin
         fails++; $display("FAIL lhu_stall got %0d cycles (now %b) exp 4 (now 0)", stall_cycles, stall); end
      tests++; if (dataOut !== 32'h0000_BEEF) begin fails++; $display("FAIL lhu_data got %h exp 0000beef", dataOut); end
      tests++; if (writeEnabled_echo !== 1'b1 || rdAddress !== 5'd7) begin
         fails++; $display("FAIL lhu_wr got we=%b rd=%0d exp we=1 rd=7", writeEnabled_echo, rdAddress); end
      step();
   endtask

   task automatic test_misaligned();
      issue(12'h103, 5'd9, 32'h201);
      tests++; if (misaligned !== 1'b1) begin fails++; $display("FAIL mis_pulse got %b exp 1", misaligned); end
      tests++; if (mem.memReadReq !== 1'b0 || stall !== 1'b0 || writeEnabled_echo !== 1'b0) begin
         fails++; $display("FAIL mis_ctl got req=%b stall=%b we=%b exp 0 0 0", mem.memReadReq, stall, writeEnabled_echo); end
      tests++; if (dataOut !== 32'h0000_BEEF || rdAddress !== 5'd7) begin
         fails++; $display("FAIL mis_hold got data=%h rd=%0d exp 0000beef 7", dataOut, rdAddress); end
      step();
      tests++; if (misaligned !== 1'b0) begin fails++; $display("FAIL mis_end got %b exp 0", misaligned); end
   endtask

   task automatic test_timeout();
      issue(12'h103, 5'd10, 32'h300);
      for (int i = 0; i < 15; i++) step();
      tests++; if (stall !== 1'b1 || busError !== 1'b0) begin
         fails++; $display("FAIL to_pre got stall=%b berr=%b exp 1 0", stall, busError); end
      step();
      tests++; if (busError !== 1'b1 || mem.memReadReq !== 1'b0 || stall !== 1'b0) begin
         fails++; $display("FAIL to_abort got berr=%b req=%b stall=%b exp 1 0 0", busError, mem.memReadReq, stall); end
      tests++; if (writeEnabled_echo !== 1'b0) begin fails++; $display("FAIL to_nowr got %b exp 0", writeEnabled_echo); end
      step();
      tests++; if (busError !== 1'b0) begin fails++; $display("FAIL to_pulse got %b exp 0", busError); end
      // memReady on the final allowed cycle completes normally
      issue(12'h103, 5'd10, 32'h300);
      for (int i = 0; i < 15; i++) step();
      mem.memReady = 1'b1; mem.memData = 32'hCAFE_F00D;
      step();
      mem.memReady = 1'b0;
      tests++; if (busError !== 1'b0 || writeEnabled_echo !== 1'b1) begin
         fails++; $display("FAIL to_last got berr=%b we=%b exp 0 1", busError, writeEnabled_echo); end
      tests++; if (dataOut !== 32'hCAFE_F00D) begin fails++; $display("FAIL to_last_data got %h exp cafef00d", dataOut); end
      step();
   endtask

   task automatic test_reset_mid_wait();
      issue(12'h103, 5'd11, 32'h400);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests++; if (mem.memReadReq !== 1'b0 || mem.memAddress !== 32'h0 || stall !== 1'b0) begin
         fails++; $display("FAIL rw_bus got req=%b addr=%h stall=%b exp 0 0 0", mem.memReadReq, mem.memAddress, stall); end
      tests++; if (dataOut !== 32'h0 || rdAddress !== 5'd0 || writeEnabled_echo !== 1'b0) begin
         fails++; $display("FAIL rw_out got data=%h rd=%0d we=%b exp 0", dataOut, rdAddress, writeEnabled_echo); end
      mem.memReady = 1'b1; mem.memData = 32'h5555_AAAA;
      step();
      mem.memReady = 1'b0;
      tests++; if (writeEnabled_echo !== 1'b0 || dataOut !== 32'h0) begin
         fails++; $display("FAIL rw_late got we=%b data=%h exp 0 0", writeEnabled_echo, dataOut); end
   endtask

   task automatic test_rd_zero();
      mem.memReady = 1'b1; mem.memData = 32'h1122_3344;
      issue(12'h103, 5'd0, 32'h500);
      step();
      mem.memReady = 1'b0;
      tests++; if (writeEnabled_echo !== 1'b0 || stall !== 1'b0) begin
         fails++; $display("FAIL rd0 got we=%b stall=%b exp 0 0", writeEnabled_echo, stall); end
      tests++; if (dataOut !== 32'h1122_3344) begin fails++; $display("FAIL rd0_data got %h exp 11223344", dataOut); end
   endtask

   task automatic test_back_to_back();
      // LH sign-extend followed immediately by a pass-through
      mem.memReady = 1'b1; mem.memData = 32'h0000_8001;
      issue(12'h083, 5'd12, 32'h600);
      step();
      mem.memReady = 1'b0;
      tests++; if (dataOut !== 32'hFFFF_8001 || writeEnabled_echo !== 1'b1) begin
         fails++; $display("FAIL b2b_lh got data=%h we=%b exp ffff8001 1", dataOut, writeEnabled_echo); end
      issue(12'h013, 5'd13, 32'h0000_0042);
      tests++; if (dataOut !== 32'h42 || rdAddress !== 5'd13 || writeEnabled_echo !== 1'b1) begin
         fails++; $display("FAIL b2b_pt got data=%h rd=%0d we=%b exp 42 13 1", dataOut, rdAddress, writeEnabled_echo); end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_lb_sext();
      test_lhu_wait();
      test_misaligned();
      test_timeout();
      test_reset_mid_wait();
      test_rd_zero();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
